keypad_entry: RTL and testbench

//   Input end of the calculator datapath. Scans a 4x4 matrix keypad and

---
 rtl/keypad_entry.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_keypad_entry.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - 4x4 keypad scanner, debouncer and BCD entry assembler
//
// Purpose: scans a 4x4 active-low matrix keypad one row per SCAN_DIV clocks,
//    debounces whole-scan results, packs digit keys into an 8-digit BCD entry
//    and issues operator/equals keys as one-cycle command pulses.
//
// Ports:
//    clk          system clock, all state changes on posedge
//    rst_n        synchronous reset, active-low
//    row_out      keypad row drive, active-low, one bit low at a time
//    col_in       keypad columns, active-low, asynchronous to clk
//    entry        live packed-BCD entry, digit 0 in [3:0]
//    digit_cnt    number of digits entered, 0..8
//    key_valid    one-cycle pulse on each accepted key press
//    key_code     code of the last accepted key
//    cmd_valid    one-cycle pulse when a command is issued
//    cmd          0 '+', 1 '-', 2 '*', 3 '/', 4 '='
//    cmd_operand  entry value captured when the command was issued

module keypad_entry #(
   parameter logic [19:0] SCAN_DIV = 20'd100000,
   parameter logic [3:0]  DEBOUNCE = 4'd8
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [3:0]  row_out,
   input  logic [3:0]  col_in,
   output logic [31:0] entry,
   output logic [3:0]  digit_cnt,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        cmd_valid,
   output logic [2:0]  cmd,
   output logic [31:0] cmd_operand
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   localparam logic [3:0] KEY_CLR = 4'd14;
   localparam logic [3:0] KEY_EQ  = 4'd15;

   // Fixed translation from matrix position {row, col} to key code.
   function automatic logic [3:0] key_map(input logic [3:0] pos);
      logic [3:0] code;
      case (pos)
         4'd0:    code = 4'd1;
         4'd1:    code = 4'd2;
         4'd2:    code = 4'd3;
         4'd3:    code = 4'd10;
         4'd4:    code = 4'd4;
         4'd5:    code = 4'd5;
         4'd6:    code = 4'd6;
         4'd7:    code = 4'd11;
         4'd8:    code = 4'd7;
         4'd9:    code = 4'd8;
         4'd10:   code = 4'd9;
         4'd11:   code = 4'd12;
         4'd12:   code = KEY_CLR;
         4'd13:   code = 4'd0;
         4'd14:   code = KEY_EQ;
         default: code = 4'd13;
      endcase
      return code;
   endfunction

   // Synchronizer and scan timing
   logic [3:0]  sync1_q, sync1_d;
   logic [3:0]  sync2_q, sync2_d;
   logic [19:0] slot_q, slot_d;
   logic [1:0]  row_idx_q, row_idx_d;
   logic [3:0]  row_out_q, row_out_d;

   // Per-scan accumulation: number of low keys seen so far (saturates at 2)
   // and the position of the last single hit.
   logic [1:0]  hits_q, hits_d;
   logic [3:0]  hit_pos_q, hit_pos_d;

   // Debounce FSM
   state_t      state_q, state_d;
   logic [3:0]  cand_q, cand_d;
   logic [3:0]  n_q, n_d;

   // Outputs
   logic [31:0] entry_q, entry_d;
   logic [3:0]  digit_cnt_q, digit_cnt_d;
   logic        key_valid_q, key_valid_d;
   logic [3:0]  key_code_q, key_code_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [2:0]  cmd_q, cmd_d;
   logic [31:0] cmd_operand_q, cmd_operand_d;

   // Scan decode
   logic        sample_now;
   logic        scan_done;
   logic [3:0]  low_cols;
   logic [2:0]  row_hits;
   logic [1:0]  col_idx;
   logic [2:0]  hits_base;
   logic [2:0]  hits_tot;
   logic [1:0]  hits_new;
   logic [3:0]  pos_new;
   logic        res_key;
   logic [3:0]  res_code;
   logic        accept;
   logic [4:0]  n_inc;

   always_comb begin
      sample_now = (slot_q == SCAN_DIV - 20'd1);
      scan_done  = sample_now && (row_idx_q == 2'd3);
      low_cols   = ~sync2_q;
      row_hits   = {2'b00, low_cols[0]} + {2'b00, low_cols[1]}
                 + {2'b00, low_cols[2]} + {2'b00, low_cols[3]};
      // Only meaningful when exactly one column is low.
      col_idx = 2'd0;
      if (low_cols[3]) col_idx = 2'd3;
      if (low_cols[2]) col_idx = 2'd2;
      if (low_cols[1]) col_idx = 2'd1;
      if (low_cols[0]) col_idx = 2'd0;
      // Row 0 starts a fresh scan, so earlier totals are discarded there.
      hits_base = (row_idx_q == 2'd0) ? 3'd0 : {1'b0, hits_q};
      hits_tot  = hits_base + row_hits;
      hits_new  = (hits_tot >= 3'd2) ? 2'd2 : hits_tot[1:0];
      pos_new   = (row_hits == 3'd1) ? {row_idx_q, col_idx} : hit_pos_q;
      // Full-scan result including the row sampled this cycle.
      res_key   = (hits_new == 2'd1);
      res_code  = key_map(pos_new);
      n_inc     = {1'b0, n_q} + 5'd1;
   end

   always_comb begin
      sync1_d       = col_in;
      sync2_d       = sync1_q;
      slot_d        = slot_q;
      row_idx_d     = row_idx_q;
      row_out_d     = row_out_q;
      hits_d        = hits_q;
      hit_pos_d     = hit_pos_q;
      state_d       = state_q;
      cand_d        = cand_q;
      n_d           = n_q;
      entry_d       = entry_q;
      digit_cnt_d   = digit_cnt_q;
      key_valid_d   = 1'b0;
      key_code_d    = key_code_q;
      cmd_valid_d   = 1'b0;
      cmd_d         = cmd_q;
      cmd_operand_d = cmd_operand_q;
      accept        = 1'b0;

      if (sample_now) begin
         slot_d    = 20'd0;
         row_idx_d = row_idx_q + 2'd1;
         row_out_d = {row_out_q[2:0], row_out_q[3]};
         hits_d    = hits_new;
         hit_pos_d = pos_new;
      end else begin
         slot_d = slot_q + 20'd1;
      end

      if (scan_done) begin
         case (state_q)
            IDLE: begin
               if (res_key) begin
                  cand_d = res_code;
                  n_d    = 4'd1;
                  if (5'd1 >= {1'b0, DEBOUNCE}) begin
                     state_d = HELD;
                     accept  = 1'b1;
                  end else begin
                     state_d = PRESS_DB;
                  end
               end
            end
            PRESS_DB: begin
               if (res_key && (res_code == cand_q)) begin
                  n_d = n_inc[3:0];
                  if (n_inc >= {1'b0, DEBOUNCE}) begin
                     state_d = HELD;
                     accept  = 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            HELD: begin
               // A different key while held is ignored; no auto-repeat.
               if (!res_key) begin
                  n_d     = 4'd1;
                  state_d = (5'd1 >= {1'b0, DEBOUNCE}) ? IDLE : REL_DB;
               end
            end
            default: begin
               if (!res_key) begin
                  n_d = n_inc[3:0];
                  if (n_inc >= {1'b0, DEBOUNCE}) state_d = IDLE;
               end else begin
                  state_d = HELD;
               end
            end
         endcase
      end

      if (accept) begin
         key_valid_d = 1'b1;
         key_code_d  = cand_d;
         if (cand_d <= 4'd9) begin
            if (digit_cnt_q < 4'd8) begin
               entry_d     = {entry_q[27:0], cand_d};
               digit_cnt_d = digit_cnt_q + 4'd1;
            end
         end else if (cand_d == KEY_CLR) begin
            entry_d     = 32'd0;
            digit_cnt_d = 4'd0;
         end else begin
            cmd_valid_d   = 1'b1;
            cmd_operand_d = entry_q;
            entry_d       = 32'd0;
            digit_cnt_d   = 4'd0;
            case (cand_d)
               4'd10:   cmd_d = 3'd0;
               4'd11:   cmd_d = 3'd1;
               4'd12:   cmd_d = 3'd2;
               4'd13:   cmd_d = 3'd3;
               default: cmd_d = 3'd4;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q       <= 4'b1111;
         sync2_q       <= 4'b1111;
         slot_q        <= 20'd0;
         row_idx_q     <= 2'd0;
         row_out_q     <= 4'b1110;
         hits_q        <= 2'd0;
         hit_pos_q     <= 4'd0;
         state_q       <= IDLE;
         cand_q        <= 4'd0;
         n_q           <= 4'd0;
         entry_q       <= 32'd0;
         digit_cnt_q   <= 4'd0;
         key_valid_q   <= 1'b0;
         key_code_q    <= 4'd0;
         cmd_valid_q   <= 1'b0;
         cmd_q         <= 3'd0;
         cmd_operand_q <= 32'd0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         slot_q        <= slot_d;
         row_idx_q     <= row_idx_d;
         row_out_q     <= row_out_d;
         hits_q        <= hits_d;
         hit_pos_q     <= hit_pos_d;
         state_q       <= state_d;
         cand_q        <= cand_d;
         n_q           <= n_d;
         entry_q       <= entry_d;
         digit_cnt_q   <= digit_cnt_d;
         key_valid_q   <= key_valid_d;
         key_code_q    <= key_code_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_q         <= cmd_d;
         cmd_operand_q <= cmd_operand_d;
      end
   end

   assign row_out     = row_out_q;
   assign entry       = entry_q;
   assign digit_cnt   = digit_cnt_q;
   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd         = cmd_q;
   assign cmd_operand = cmd_operand_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard bench for keypad_entry

module tb_keypad_entry;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row_out;
   logic [3:0]  col_in;
   logic [31:0] entry;
   logic [3:0]  digit_cnt;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        cmd_valid;
   logic [2:0]  cmd;
   logic [31:0] cmd_operand;

   always #5 clk = ~clk;

   keypad_entry #(
      .SCAN_DIV (20'd4),
      .DEBOUNCE (4'd2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_out     (row_out),
      .col_in      (col_in),
      .entry       (entry),
      .digit_cnt   (digit_cnt),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .cmd_valid   (cmd_valid),
      .cmd         (cmd),
      .cmd_operand (cmd_operand)
   );

   // Passive matrix: a pressed key pulls its column low while its row is driven.
   logic [15:0] pmask;
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!row_out[r])
            for (int c = 0; c < 4; c++)
               if (pmask[r*4+c]) col_in[c] = 1'b0;
   end

   int tests = 0;
   int fails = 0;

   logic [39:0] kq[$];   // {key_code, entry, digit_cnt} expected at key_valid
   logic [34:0] cq[$];   // {cmd, cmd_operand} expected at cmd_valid
   logic [31:0] m_entry;
   logic [3:0]  m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a pulse.
   initial begin
      logic kv_prev, cv_prev;
      logic [39:0] ke;
      logic [34:0] ce;
      kv_prev = 1'b0;
      cv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (key_valid) begin
            tests++;
            if (kv_prev) begin
               fails++;
               $display("FAIL key_valid_width: high for 2 cycles");
            end else if (kq.size() == 0) begin
               fails++;
               $display("FAIL key_unexpected: key_code=%0d expected no pulse", key_code);
            end else begin
               ke = kq.pop_front();
               if ({key_code, entry, digit_cnt} !== ke) begin
                  fails++;
                  $display("FAIL key_pulse: got code=%0d entry=%h cnt=%0d expected code=%0d entry=%h cnt=%0d",
                           key_code, entry, digit_cnt, ke[39:36], ke[35:4], ke[3:0]);
               end
            end
         end
         if (cmd_valid) begin
            tests++;
            if (cv_prev) begin
               fails++;
               $display("FAIL cmd_valid_width: high for 2 cycles");
            end else if (cq.size() == 0) begin
               fails++;
               $display("FAIL cmd_unexpected: cmd=%0d expected no pulse", cmd);
            end else begin
               ce = cq.pop_front();
               if ({cmd, cmd_operand} !== ce) begin
                  fails++;
                  $display("FAIL cmd_pulse: got cmd=%0d op=%h expected cmd=%0d op=%h",
                           cmd, cmd_operand, ce[34:32], ce[31:0]);
               end
            end
         end
         kv_prev = key_valid;
         cv_prev = cmd_valid;
      end
   end

   function automatic int pos_of(input logic [3:0] code);
      case (code)
         4'd1:  return 0;
         4'd2:  return 1;
         4'd3:  return 2;
         4'd10: return 3;
         4'd4:  return 4;
         4'd5:  return 5;
         4'd6:  return 6;
         4'd11: return 7;
         4'd7:  return 8;
         4'd8:  return 9;
         4'd9:  return 10;
         4'd12: return 11;
         4'd14: return 12;
         4'd0:  return 13;
         4'd15: return 14;
         default: return 15;
      endcase
   endfunction

   // Reference model of one accepted key: updates entry and queues expectations.
   task automatic expect_key(input logic [3:0] code);
      logic [2:0] c;
      if (code <= 4'd9) begin
         if (m_cnt < 4'd8) begin
            m_entry = {m_entry[27:0], code};
            m_cnt   = m_cnt + 4'd1;
         end
      end else if (code == 4'd14) begin
         m_entry = 32'd0;
         m_cnt   = 4'd0;
      end else begin
         case (code)
            4'd10:   c = 3'd0;
            4'd11:   c = 3'd1;
            4'd12:   c = 3'd2;
            4'd13:   c = 3'd3;
            default: c = 3'd4;
         endcase
         cq.push_back({c, m_entry});
         m_entry = 32'd0;
         m_cnt   = 4'd0;
      end
      kq.push_back({code, m_entry, m_cnt});
   endtask

   // Hold one key for hold_scans full scans (16 clks each), then release.
   task automatic press(input logic [3:0] code, input int hold_scans);
      pmask = 16'd0;
      pmask[pos_of(code)] = 1'b1;
      repeat (hold_scans * 16) @(negedge clk);
      pmask = 16'd0;
      repeat (4 * 16) @(negedge clk);
   endtask

   task automatic key(input logic [3:0] code);
      expect_key(code);
      press(code, 5);
   endtask

   task automatic wait_row(input logic [3:0] r);
      int k;
      k = 0;
      while (row_out != r && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (row_out != r) begin
         tests++;
         fails++;
         $display("FAIL wait_row: row_out=%b expected %b within 40 clks", row_out, r);
      end
   endtask

   initial begin
      logic [3:0] exp_row;
      rst_n   = 1'b0;
      pmask   = 16'd0;
      m_entry = 32'd0;
      m_cnt   = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_row_out", {28'd0, row_out}, 32'he);
      chk("rst_entry", entry, 32'd0);
      chk("rst_digit_cnt", {28'd0, digit_cnt}, 32'd0);
      chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
      chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      rst_n = 1'b1;

      // Idle: after k clocks, the row slot is (k/4) mod 4.
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         exp_row = ~(4'b0001 << ((k / 4) % 4));
         chk("idle_row_out", {28'd0, row_out}, {28'd0, exp_row});
      end
      chk("idle_entry", entry, 32'd0);

      // Clean presses
      key(4'd1);
      key(4'd2);
      key(4'd3);
      chk("123_entry", entry, 32'h0000_0123);
      chk("123_cnt", {28'd0, digit_cnt}, 32'd3);

      // Nine digits: last one only pulses key_valid
      key(4'd14);
      for (int d = 1; d <= 9; d++) key(4'(d));
      chk("9dig_entry", entry, 32'h1234_5678);
      chk("9dig_cnt", {28'd0, digit_cnt}, 32'd8);

      // Operator and equals
      key(4'd14);
      key(4'd4);
      key(4'd2);
      key(4'd10);
      chk("plus_entry", entry, 32'd0);
      chk("plus_cnt", {28'd0, digit_cnt}, 32'd0);
      key(4'd7);
      key(4'd15);
      chk("eq_entry", entry, 32'd0);

      // Bounce '5' on alternate scans, then hold: exactly one accept
      for (int i = 0; i < 3; i++) begin
         pmask = 16'd0;
         pmask[pos_of(4'd5)] = 1'b1;
         repeat (16) @(negedge clk);
         pmask = 16'd0;
         repeat (16) @(negedge clk);
      end
      key(4'd5);
      chk("bounce_entry", entry, 32'd5);

      // Two keys together: no accept
      pmask = 16'd0;
      pmask[pos_of(4'd7)] = 1'b1;
      pmask[pos_of(4'd8)] = 1'b1;
      repeat (5 * 16) @(negedge clk);
      pmask = 16'd0;
      repeat (4 * 16) @(negedge clk);
      chk("dual_entry", entry, 32'd5);
      chk("dual_cnt", {28'd0, digit_cnt}, 32'd1);

      // Reset during PRESS_DB: one full scan has seen '9', second is in progress
      wait_row(4'b0111);
      wait_row(4'b1110);
      pmask = 16'd0;
      pmask[pos_of(4'd9)] = 1'b1;
      repeat (24) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_row_out", {28'd0, row_out}, 32'he);
      chk("mid_rst_entry", entry, 32'd0);
      chk("mid_rst_cnt", {28'd0, digit_cnt}, 32'd0);
      chk("mid_rst_key_code", {28'd0, key_code}, 32'd0);
      chk("mid_rst_cmd", {29'd0, cmd}, 32'd0);
      chk("mid_rst_cmd_operand", cmd_operand, 32'd0);
      chk("mid_rst_key_valid", {31'd0, key_valid}, 32'd0);
      pmask   = 16'd0;
      m_entry = 32'd0;
      m_cnt   = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4 * 16) @(negedge clk);
      key(4'd3);
      chk("post_rst_entry", entry, 32'd3);

      chk("key_queue_empty", kq.size(), 32'd0);
      chk("cmd_queue_empty", cq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
